// File: rtl/csr_counter_unit.sv
// Machine counter CSRs (mcycle, minstret, mcountinhibit): combinational decode/read at write-back,
// write commit and counter updates on the same rising edge; no backpressure, one op per cycle.
module csr_counter_unit #(
   parameter int         CNT_W       = 64,
   parameter logic [2:0] INHIBIT_RST = 3'b000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wb_valid,
   input  logic [31:0]      wb_instr,
   input  logic [31:0]      wb_rs1_val,
   input  logic             instr_retire,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt,
   output logic             csr_hit,
   output logic [31:0]      csr_rdata,
   output logic             csr_illegal
);

   localparam logic [6:0]  OPC_SYSTEM  = 7'b1110011;
   localparam logic [11:0] A_MCYCLE    = 12'hB00;
   localparam logic [11:0] A_MCYCLEH   = 12'hB80;
   localparam logic [11:0] A_MINSTRET  = 12'hB02;
   localparam logic [11:0] A_MINSTRETH = 12'hB82;
   localparam logic [11:0] A_MCNTINH   = 12'h320;
   localparam logic [11:0] A_CYCLE     = 12'hC00;
   localparam logic [11:0] A_CYCLEH    = 12'hC80;
   localparam logic [11:0] A_INSTRET   = 12'hC02;
   localparam logic [11:0] A_INSTRETH  = 12'hC82;

   logic [CNT_W-1:0] mcycle_q;
   logic [CNT_W-1:0] minstret_q;
   logic             cy_inh_q;
   logic             ir_inh_q;

   logic [2:0]  funct3;
   logic [4:0]  rs1_fld;
   logic [11:0] csr_addr;
   logic        is_csr;
   logic        wr_intent;
   logic        mapped;
   logic        commit;
   logic [31:0] src_val;
   logic [31:0] old_val;
   logic [31:0] new_val;

   assign funct3    = wb_instr[14:12];
   assign rs1_fld   = wb_instr[19:15];
   assign csr_addr  = wb_instr[31:20];
   // funct3 000 and 100 are not CSR ops: both have funct3[1:0] == 0
   assign is_csr    = (wb_instr[6:0] == OPC_SYSTEM) && (funct3[1:0] != 2'b00);
   assign wr_intent = (funct3[1:0] == 2'b01) || (rs1_fld != 5'd0);
   assign src_val   = funct3[2] ? {27'b0, rs1_fld} : wb_rs1_val;

   always_comb begin
      mapped  = 1'b1;
      old_val = '0;
      case (csr_addr)
         A_MCYCLE,   A_CYCLE:    old_val = mcycle_q[31:0];
         A_MCYCLEH,  A_CYCLEH:   old_val = mcycle_q[CNT_W-1:32];
         A_MINSTRET, A_INSTRET:  old_val = minstret_q[31:0];
         A_MINSTRETH, A_INSTRETH: old_val = minstret_q[CNT_W-1:32];
         A_MCNTINH:              old_val = {29'b0, ir_inh_q, 1'b0, cy_inh_q};
         default:                mapped  = 1'b0;
      endcase
   end

   always_comb begin
      new_val = old_val & ~src_val;
      case (funct3[1:0])
         2'b01:   new_val = src_val;
         2'b10:   new_val = old_val | src_val;
         default: new_val = old_val & ~src_val;
      endcase
   end

   // 0xCxx user aliases are read-only
   assign csr_hit     = is_csr && mapped;
   assign csr_illegal = is_csr && (!mapped || (wr_intent && (csr_addr[11:8] == 4'hC)));
   assign csr_rdata   = csr_hit ? old_val : 32'd0;
   assign commit      = wb_valid && csr_hit && wr_intent && !csr_illegal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcycle_q   <= '0;
         minstret_q <= '0;
         cy_inh_q   <= INHIBIT_RST[0];
         ir_inh_q   <= INHIBIT_RST[2];
      end else begin
         if (commit && csr_addr == A_MCYCLE)
            mcycle_q[31:0] <= new_val;
         else if (commit && csr_addr == A_MCYCLEH)
            mcycle_q[CNT_W-1:32] <= new_val;
         else if (!cy_inh_q)
            mcycle_q <= mcycle_q + CNT_W'(1);

         // a CSR write to minstret suppresses its own retire increment
         if (commit && csr_addr == A_MINSTRET)
            minstret_q[31:0] <= new_val;
         else if (commit && csr_addr == A_MINSTRETH)
            minstret_q[CNT_W-1:32] <= new_val;
         else if (instr_retire && !ir_inh_q)
            minstret_q <= minstret_q + CNT_W'(1);

         if (commit && csr_addr == A_MCNTINH) begin
            cy_inh_q <= new_val[0];
            ir_inh_q <= new_val[2];
         end
      end
   end

   assign cycle_cnt   = mcycle_q;
   assign instret_cnt = minstret_q;

endmodule

// File: tb/tb_csr_counter_unit.sv
// Randomized and directed bench for csr_counter_unit against an architectural counter model.
module tb_csr_counter_unit;

   logic        clk;
   logic        rst_n;
   logic        wb_valid;
   logic [31:0] wb_instr;
   logic [31:0] wb_rs1_val;
   logic        instr_retire;
   logic [63:0] cycle_cnt;
   logic [63:0] instret_cnt;
   logic        csr_hit;
   logic [31:0] csr_rdata;
   logic        csr_illegal;

   int n_tests = 0;
   int n_fail  = 0;

   // architectural state of the model
   logic [63:0] m_cyc;
   logic [63:0] m_ins;
   bit          m_cy_inh;
   bit          m_ir_inh;

   logic [11:0] addr_list [9] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h320,
                                  12'hC00, 12'hC80, 12'hC02, 12'hC82};

   csr_counter_unit #(.CNT_W(64), .INHIBIT_RST(3'b000)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wb_valid     (wb_valid),
      .wb_instr     (wb_instr),
      .wb_rs1_val   (wb_rs1_val),
      .instr_retire (instr_retire),
      .cycle_cnt    (cycle_cnt),
      .instret_cnt  (instret_cnt),
      .csr_hit      (csr_hit),
      .csr_rdata    (csr_rdata),
      .csr_illegal  (csr_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mk_instr(input logic [11:0] a, input logic [4:0] rs1f,
                                            input logic [2:0] f3);
      return {a, rs1f, f3, 5'd1, 7'b1110011};
   endfunction

   // Architectural CSR read; returns 0 and mapped=0 for unknown addresses.
   function automatic logic [31:0] m_read(input logic [11:0] a, output bit mapped);
      mapped = 1'b1;
      case (a)
         12'hB00, 12'hC00: return m_cyc[31:0];
         12'hB80, 12'hC80: return m_cyc[63:32];
         12'hB02, 12'hC02: return m_ins[31:0];
         12'hB82, 12'hC82: return m_ins[63:32];
         12'h320:          return {29'b0, m_ir_inh, 1'b0, m_cy_inh};
         default: begin
            mapped = 1'b0;
            return 32'd0;
         end
      endcase
   endfunction

   task automatic m_reset();
      m_cyc = 64'd0;
      m_ins = 64'd0;
      m_cy_inh = 1'b0;
      m_ir_inh = 1'b0;
   endtask

   // One cycle: drive at negedge, check decode, advance model at posedge, check counters.
   task automatic step(input logic vld, input logic [31:0] ins, input logic [31:0] rs1v,
                       input logic ret);
      logic [2:0]  f3;
      logic [11:0] a;
      logic [4:0]  rs1f;
      bit          mapped, is_op, writes, e_hit, e_ill;
      logic [31:0] oldv, src, nv;
      bit          cyc_written, ins_written;
      logic [63:0] n_cyc, n_ins;
      wb_valid = vld;
      wb_instr = ins;
      wb_rs1_val = rs1v;
      instr_retire = ret;
      #1;
      f3 = ins[14:12];
      a = ins[31:20];
      rs1f = ins[19:15];
      oldv = m_read(a, mapped);
      is_op = (ins[6:0] == 7'h73) && (f3 inside {3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7});
      writes = (f3 == 3'd1 || f3 == 3'd5) || (rs1f != 0);
      e_hit = is_op && mapped;
      e_ill = is_op && (!mapped || (writes && a >= 12'hC00 && a <= 12'hCFF));
      check_val("csr_hit", csr_hit, e_hit);
      check_val("csr_illegal", csr_illegal, e_ill);
      check_val("csr_rdata", csr_rdata, e_hit ? oldv : 32'd0);
      src = (f3 >= 3'd5) ? 32'(rs1f) : rs1v;
      if (f3 == 3'd1 || f3 == 3'd5)      nv = src;
      else if (f3 == 3'd2 || f3 == 3'd6) nv = oldv | src;
      else                               nv = oldv & ~src;
      cyc_written = 0;
      ins_written = 0;
      n_cyc = m_cyc + 64'd1;
      n_ins = m_ins + 64'(ret);
      if (vld && e_hit && writes && !e_ill) begin
         if (a == 12'hB00) begin n_cyc = {m_cyc[63:32], nv}; cyc_written = 1; end
         if (a == 12'hB80) begin n_cyc = {nv, m_cyc[31:0]};  cyc_written = 1; end
         if (a == 12'hB02) begin n_ins = {m_ins[63:32], nv}; ins_written = 1; end
         if (a == 12'hB82) begin n_ins = {nv, m_ins[31:0]};  ins_written = 1; end
      end
      if (!cyc_written && m_cy_inh) n_cyc = m_cyc;
      if (!ins_written && m_ir_inh) n_ins = m_ins;
      if (vld && e_hit && writes && !e_ill && a == 12'h320) begin
         m_cy_inh = nv[0];
         m_ir_inh = nv[2];
      end
      m_cyc = n_cyc;
      m_ins = n_ins;
      @(posedge clk);
      #1;
      check_val("cycle_cnt", cycle_cnt, m_cyc);
      check_val("instret_cnt", instret_cnt, m_ins);
      @(negedge clk);
   endtask

   initial begin
      logic [63:0] frozen;
      logic [11:0] ra;
      logic [4:0]  rf;
      logic [2:0]  f3r;
      logic [6:0]  opc;
      rst_n = 1'b0;
      wb_valid = 1'b0;
      wb_instr = 32'd0;
      wb_rs1_val = 32'd0;
      instr_retire = 1'b0;
      m_reset();
      #12;
      check_val("rst_cycle", cycle_cnt, 64'd0);
      check_val("rst_instret", instret_cnt, 64'd0);
      check_val("rst_hit", csr_hit, 1'b0);
      check_val("rst_rdata", csr_rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // idle count
      for (int i = 0; i < 10; i++) step(1'b0, 32'd0, 32'd0, 1'b0);
      check_val("idle_cycle10", cycle_cnt, 64'd10);
      check_val("idle_instret0", instret_cnt, 64'd0);

      // low-half carry into high half
      step(1'b1, mk_instr(12'hB00, 5'd2, 3'd1), 32'hFFFF_FFFF, 1'b0);
      check_val("force_lo", cycle_cnt, 64'h0000_0000_FFFF_FFFF);
      step(1'b0, 32'd0, 32'd0, 1'b0);
      check_val("carry_hi", cycle_cnt, 64'h0000_0001_0000_0000);

      // CSRRS with x0: read only, retire still counts
      for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 32'd0, 1'b1);
      step(1'b1, mk_instr(12'hB02, 5'd0, 3'd2), 32'hFFFF_FFFF, 1'b1);
      check_val("rs_x0_instret", instret_cnt, 64'd4);

      // inhibit mcycle, then release
      step(1'b1, mk_instr(12'h320, 5'd1, 3'd6), 32'd0, 1'b0);
      frozen = cycle_cnt;
      for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 32'd0, 1'b1);
      check_val("inhibit_frozen", cycle_cnt, frozen);
      step(1'b1, mk_instr(12'h320, 5'd1, 3'd7), 32'd0, 1'b0);
      check_val("clear_edge_frozen", cycle_cnt, frozen);
      step(1'b0, 32'd0, 32'd0, 1'b0);
      check_val("resume", cycle_cnt, frozen + 64'd1);

      // read-only alias write, unmapped address
      step(1'b1, mk_instr(12'hC00, 5'd3, 3'd1), 32'h1234, 1'b0);
      step(1'b1, mk_instr(12'h7C0, 5'd3, 3'd1), 32'h1234, 1'b0);

      // set mcycle to 0x5_00000010 then async reset mid-cycle
      step(1'b1, mk_instr(12'hB80, 5'd3, 3'd1), 32'h5, 1'b1);
      step(1'b1, mk_instr(12'hB00, 5'd3, 3'd1), 32'h10, 1'b1);
      check_val("preset", cycle_cnt, 64'h5_0000_0010);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("async_rst_cycle", cycle_cnt, 64'd0);
      check_val("async_rst_instret", instret_cnt, 64'd0);
      m_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         ra  = ($urandom_range(0, 11) < 9) ? addr_list[$urandom_range(0, 8)] : 12'($urandom);
         rf  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         f3r = 3'($urandom);
         opc = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'b1110011;
         step($urandom_range(0, 3) != 0, {ra, rf, f3r, 5'd1, opc},
              ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom,
              1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/csr_counter_unit.md
Name: csr_counter_unit

Overview:
- Owns the machine counter CSRs: mcycle, minstret and mcountinhibit.
- Sits upstream of the CSR read path. Supplies the 64-bit cycle count to it and answers SYSTEM CSR instructions at write-back with read data.
- Performs the architectural CSR write (CSRRW/RS/RC and their immediate forms) at the same clock edge.
- Single clock domain; all state updates on the rising edge of clk.

Parameters:
- CNT_W, 64, width of the mcycle and minstret counters; must be 64 (RV32 lo/hi split).
- INHIBIT_RST, 3'b000, reset value of mcountinhibit bits {IR, TM(reserved), CY}.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- wb_valid  input  1  instruction in write-back is valid and commits this cycle
- wb_instr  input  32  instruction word in write-back
- wb_rs1_val  input  32  rs1 register value for the register forms of the instruction
- instr_retire  input  1  one instruction retires this cycle (minstret increment request)
- cycle_cnt  output  64  current mcycle value (register output)
- instret_cnt  output  64  current minstret value (register output)
- csr_hit  output  1  wb_instr is a SYSTEM CSR op whose address this block implements
- csr_rdata  output  32  old CSR value, returned to rd
- csr_illegal  output  1  CSR op to an unimplemented address, or a write to a read-only address

Behaviour:
- Reset (async assert, sync release):
  - mcycle = 0, minstret = 0, mcountinhibit = INHIBIT_RST.
  - Outputs are then cycle_cnt = 0 and instret_cnt = 0. csr_hit, csr_rdata and csr_illegal follow from wb_instr, which is combinational.
- Decode (combinational):
  - Opcode is 1110011. funct3 selects: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI. funct3 000/100 is not a CSR op: csr_hit = 0 and csr_illegal = 0.
  - Address is instr[31:20].
  - Source operand: wb_rs1_val for register forms; zimm = {27'b0, instr[19:15]} for immediate forms.
  - Write intent: RW/RWI always write. RS/RC/RSI/RCI write only if instr[19:15] != 0.
- Address map:
  - 0xB00 mcycle[31:0], 0xB80 mcycle[63:32].
  - 0xB02 minstret[31:0], 0xB82 minstret[63:32].
  - 0x320 mcountinhibit: bits 0 and 2 are writable; bit 1 and bits [31:3] read 0.
  - Read-only aliases: 0xC00 / 0xC80 / 0xC02 / 0xC82 map to the same values as the four counter halves.
- Hit and illegal flags:
  - csr_hit = 1 for any CSR op to a mapped address.
  - csr_illegal = 1 for a CSR op to an unmapped address, or write intent to any 0xCxx address.
- Read data:
  - csr_rdata = the pre-edge value of the addressed CSR.
  - csr_rdata = 0 when csr_hit = 0.
- Write commit:
  - Occurs only when wb_valid & csr_hit & write intent & !csr_illegal.
  - new = RW: src; RS: old | src; RC: old & ~src.
- Counter update each edge, in priority order:
  1. A committed write to a half of a counter loads that half with new. The other half holds. No increment of that counter this cycle.
  2. Otherwise mcycle increments by 1 when mcountinhibit.CY = 0.
  3. Otherwise (for minstret) minstret increments by 1 when instr_retire & !mcountinhibit.IR.
- Counter width and self-counting:
  - Counters wrap from 2^64-1 to 0, with carry from the low half into the high half.
  - A CSR instruction that writes minstret and also retires does not additionally increment minstret in that cycle.
- mcountinhibit write:
  - Takes effect for increments from the next edge onward.
  - In the write cycle, increments use the old inhibit value.
- wb_valid = 0: no writes commit; counters still count normally.
- Reset mid-count: counters and inhibit clear immediately, regardless of clock.

Test Plan:
- Release reset, idle 10 cycles with instr_retire=0 -> cycle_cnt=10, instret_cnt=0, csr_rdata=0.
- Force mcycle low half to 0xFFFFFFFF via CSRRW 0xB00 (rs1_val=0xFFFFFFFF), then count 1 cycle -> mcycle = 0x00000001_00000000.
- CSRRS 0xB02 with rs1 field x0 while instr_retire=1 -> csr_hit=1, csr_rdata=old minstret[31:0], no write, minstret increments by 1.
- CSRRSI 0x320 zimm=1, then 5 cycles -> cycle_cnt frozen at its post-write value. CSRRCI 0x320 zimm=1 -> counting resumes the edge after.
- CSRRW 0xC00 rs1_val=0x1234 -> csr_illegal=1, mcycle unaffected and still incrementing. CSRRW 0x7C0 -> csr_hit=0, csr_illegal=1, csr_rdata=0.
- Assert rst_n=0 asynchronously mid-cycle with counters at 0x5_00000010 -> cycle_cnt and instret_cnt go to 0 before the next clk edge.
